// File: rtl/aes_block_loader.sv
// aes_block_loader: assembles a 128-bit key and plaintext from a 32-bit valid/ready
// word stream, launches them to the cipher core and holds them for LATENCY cycles.
module aes_block_loader #(
    parameter int LATENCY   = 11,
    parameter bit KEY_REUSE = 1'b1
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic         IN_SEL,
    input  logic [31:0]  IN_DATA,
    output logic [127:0] PLAIN_TXT,
    output logic [127:0] AESKEY,
    output logic         BLK_VALID,
    output logic         BUSY,
    output logic         KEY_LOADED
);
    localparam int HW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {COLLECT, LAUNCH, HOLD} state_t;

    state_t         state_q, state_d;
    logic           ready_en_q;
    logic [1:0]     key_cnt_q, key_cnt_d;
    logic [1:0]     txt_cnt_q, txt_cnt_d;
    logic [HW-1:0]  hold_cnt_q, hold_cnt_d;
    logic [127:0]   key_stage_q, key_stage_d;
    logic [127:0]   txt_stage_q, txt_stage_d;
    logic [127:0]   plain_q, plain_d;
    logic [127:0]   aeskey_q, aeskey_d;
    logic           blk_valid_q, blk_valid_d;
    logic           key_loaded_q, key_loaded_d;
    logic           txt_full_q, txt_full_d;
    logic           accept;

    // A text word arriving while a full plaintext waits for its key is stalled.
    assign IN_READY   = ready_en_q & (state_q == COLLECT) & ~(~IN_SEL & txt_full_q);
    assign accept     = IN_VALID & IN_READY;
    assign PLAIN_TXT  = plain_q;
    assign AESKEY     = aeskey_q;
    assign BLK_VALID  = blk_valid_q;
    assign BUSY       = (state_q != COLLECT);
    assign KEY_LOADED = key_loaded_q;

    always_comb begin
        state_d      = state_q;
        key_cnt_d    = key_cnt_q;
        txt_cnt_d    = txt_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        key_stage_d  = key_stage_q;
        txt_stage_d  = txt_stage_q;
        plain_d      = plain_q;
        aeskey_d     = aeskey_q;
        blk_valid_d  = 1'b0;
        key_loaded_d = key_loaded_q;
        txt_full_d   = txt_full_q;

        if (accept && IN_SEL) begin
            for (int i = 0; i < 4; i++) begin
                if (key_cnt_q == 2'(i)) begin
                    key_stage_d[(3-i)*32 +: 32] = IN_DATA;
                end
            end
            key_cnt_d = key_cnt_q + 2'd1;
            if (key_cnt_q == 2'd0) key_loaded_d = 1'b0;
            if (key_cnt_q == 2'd3) key_loaded_d = 1'b1;
        end

        if (accept && !IN_SEL) begin
            for (int i = 0; i < 4; i++) begin
                if (txt_cnt_q == 2'(i)) begin
                    txt_stage_d[(3-i)*32 +: 32] = IN_DATA;
                end
            end
            txt_cnt_d = txt_cnt_q + 2'd1;
            if (txt_cnt_q == 2'd3) txt_full_d = 1'b1;
        end

        case (state_q)
            COLLECT: begin
                // Either the last key word or the last text word may complete the pair.
                if (txt_full_d && key_loaded_d) state_d = LAUNCH;
            end
            LAUNCH: begin
                plain_d     = txt_stage_q;
                aeskey_d    = key_stage_q;
                blk_valid_d = 1'b1;
                txt_full_d  = 1'b0;
                hold_cnt_d  = HW'(LATENCY - 1);
                if (!KEY_REUSE) begin
                    key_loaded_d = 1'b0;
                    key_cnt_d    = 2'd0;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = COLLECT;
                end else begin
                    hold_cnt_d = hold_cnt_q - HW'(1);
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= COLLECT;
            ready_en_q   <= 1'b0;
            key_cnt_q    <= 2'd0;
            txt_cnt_q    <= 2'd0;
            hold_cnt_q   <= '0;
            key_stage_q  <= '0;
            txt_stage_q  <= '0;
            plain_q      <= '0;
            aeskey_q     <= '0;
            blk_valid_q  <= 1'b0;
            key_loaded_q <= 1'b0;
            txt_full_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ready_en_q   <= 1'b1;
            key_cnt_q    <= key_cnt_d;
            txt_cnt_q    <= txt_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            key_stage_q  <= key_stage_d;
            txt_stage_q  <= txt_stage_d;
            plain_q      <= plain_d;
            aeskey_q     <= aeskey_d;
            blk_valid_q  <= blk_valid_d;
            key_loaded_q <= key_loaded_d;
            txt_full_q   <= txt_full_d;
        end
    end
endmodule

// File: tb/tb_aes_block_loader.sv
// tb_aes_block_loader: scoreboard bench for aes_block_loader with two instances
// (key reuse on / off) checked against a word-level block model.
`timescale 1ns/1ps
module tb_aes_block_loader;
    localparam int LAT1 = 11;
    localparam int LAT0 = 4;

    typedef struct {
        logic [127:0] txt;
        logic [127:0] key;
        int           cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [1:0]        iv = '0;
    logic [1:0]        isel = '0;
    logic [1:0][31:0]  idata = '0;
    logic [1:0]        ir, blk, busy, kl;
    logic [1:0][127:0] ptxt, akey;

    int asserts = 0;
    int fails   = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    aes_block_loader #(.LATENCY(LAT0), .KEY_REUSE(1'b0)) dut0 (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(iv[0]), .IN_READY(ir[0]),
        .IN_SEL(isel[0]), .IN_DATA(idata[0]), .PLAIN_TXT(ptxt[0]), .AESKEY(akey[0]),
        .BLK_VALID(blk[0]), .BUSY(busy[0]), .KEY_LOADED(kl[0])
    );
    aes_block_loader #(.LATENCY(LAT1), .KEY_REUSE(1'b1)) dut1 (
        .CLK(clk), .RESET_N(rst_n), .IN_VALID(iv[1]), .IN_READY(ir[1]),
        .IN_SEL(isel[1]), .IN_DATA(idata[1]), .PLAIN_TXT(ptxt[1]), .AESKEY(akey[1]),
        .BLK_VALID(blk[1]), .BUSY(busy[1]), .KEY_LOADED(kl[1])
    );

    // ---------------- reference model (word groups -> blocks) ----------------
    logic [127:0] m_kbuf [2];
    logic [127:0] m_key  [2];
    logic [127:0] m_tbuf [2];
    int           m_kcnt [2];
    int           m_tcnt [2];
    bit           m_kl   [2];
    bit           m_tf   [2];
    exp_t         q0 [$];
    exp_t         q1 [$];

    function automatic int lat(input int d);
        return (d == 1) ? LAT1 : LAT0;
    endfunction

    function automatic int qsize(input int d);
        return (d == 1) ? q1.size() : q0.size();
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_kbuf[d] = '0; m_key[d] = '0; m_tbuf[d] = '0;
            m_kcnt[d] = 0;  m_tcnt[d] = 0; m_kl[d] = 0; m_tf[d] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic model_accept(input int d, input logic sel, input logic [31:0] data);
        exp_t e;
        if (sel) begin
            if (m_kcnt[d] == 0) m_kl[d] = 0;
            m_kbuf[d] = {m_kbuf[d][95:0], data};
            m_kcnt[d]++;
            if (m_kcnt[d] == 4) begin
                m_kcnt[d] = 0; m_kl[d] = 1; m_key[d] = m_kbuf[d];
            end
        end else begin
            m_tbuf[d] = {m_tbuf[d][95:0], data};
            m_tcnt[d]++;
            if (m_tcnt[d] == 4) begin
                m_tcnt[d] = 0; m_tf[d] = 1;
            end
        end
        if (m_tf[d] && m_kl[d]) begin
            e.txt = m_tbuf[d];
            e.key = m_key[d];
            e.cyc = cyc + 2;  // accept edge, launch edge, then visible
            if (d == 1) q1.push_back(e); else q0.push_back(e);
            m_tf[d] = 0;
            if (d == 0) m_kl[d] = 0;
        end
    endtask

    // ---------------- comparison helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        asserts++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic req);
        chk(name, {127'b0, act}, {127'b0, req});
    endtask

    task automatic chki(input string name, input int act, input int req);
        chk(name, 128'(act), 128'(req));
    endtask

    task automatic check_zero(input int d);
        chk("rst_plain", ptxt[d], '0);
        chk("rst_key", akey[d], '0);
        chk1("rst_blk", blk[d], 1'b0);
        chk1("rst_busy", busy[d], 1'b0);
        chk1("rst_keyloaded", kl[d], 1'b0);
        chk1("rst_ready", ir[d], 1'b0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    int           run   [2] = '{0, 0};
    int           rviol [2] = '{0, 0};
    int           sviol [2] = '{0, 0};
    logic [127:0] h_txt [2];
    logic [127:0] h_key [2];

    always @(negedge clk) begin
        exp_t e;
        bit   have;
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                run[d] = 0; rviol[d] = 0; sviol[d] = 0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (blk[d]) begin
                    have = 0;
                    if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
                    if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
                    if (!have) begin
                        asserts++; fails++;
                        $display("FAIL unexpected_blk d%0d: actual BLK_VALID=1 required 0 (no block pending)", d);
                    end else begin
                        chk("blk_plain", ptxt[d], e.txt);
                        chk("blk_key", akey[d], e.key);
                        chki("blk_cycle", cyc, e.cyc);
                        $display("d%0d block launched cycle %0d txt=%h key=%h", d, cyc, ptxt[d], akey[d]);
                    end
                    h_txt[d] = ptxt[d];
                    h_key[d] = akey[d];
                end
                if (busy[d]) begin
                    run[d]++;
                    if (ir[d]) rviol[d]++;
                    if (run[d] > 1 && (ptxt[d] !== h_txt[d] || akey[d] !== h_key[d])) sviol[d]++;
                end else if (run[d] > 0) begin
                    chki("busy_length", run[d], lat(d) + 1);
                    chki("ready_while_busy", rviol[d], 0);
                    chki("hold_stable", sviol[d], 0);
                    run[d] = 0; rviol[d] = 0; sviol[d] = 0;
                end
            end
        end
    end

    // ---------------- driver tasks (entered at a falling edge) ----------------
    task automatic send(input int d, input logic sel, input logic [31:0] data);
        bit done = 0;
        iv[d] = 1'b1; isel[d] = sel; idata[d] = data;
        for (int t = 0; t < 200 && !done; t++) begin
            #1;
            if (ir[d]) begin
                model_accept(d, sel, data);
                $display("d%0d accept sel=%0d data=%h cycle %0d", d, sel, data, cyc);
                done = 1;
                @(posedge clk);
            end
            @(negedge clk);
        end
        iv[d] = 1'b0;
        if (!done) begin
            asserts++; fails++;
            $display("FAIL send_timeout d%0d: word %h actual not accepted, required accept within 200 cycles", d, data);
        end
    endtask

    task automatic wait_idle(input int d);
        int t = 0;
        while (t < 200 && (busy[d] || qsize(d) != 0)) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            asserts++; fails++;
            $display("FAIL idle_timeout d%0d: actual busy=%0d pending=%0d, required idle", d, busy[d], qsize(d));
        end
    endtask

    task automatic release_reset();
        #2 rst_n = 1'b1;
        #1;
        chk1("ready_after_release_c1_d0", ir[0], 1'b0);
        chk1("ready_after_release_c1_d1", ir[1], 1'b0);
        @(negedge clk);
        chk1("ready_after_release_c2_d0", ir[0], 1'b1);
        chk1("ready_after_release_c2_d1", ir[1], 1'b1);
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        check_zero(0);
        check_zero(1);
        model_reset();
        @(negedge clk);
        release_reset();
    endtask

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] T1 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] T2 = 128'hb34d56f78a90c2b1094cd62b0e3445cb;

    initial begin
        logic [127:0] w;
        int           cnt;
        logic         sel;
        model_reset();

        // Power-on reset and release
        @(negedge clk);
        check_zero(0);
        check_zero(1);
        release_reset();

        // Reset mid-transfer discards partial key and text
        send(1, 1'b1, 32'h11111111);
        send(1, 1'b1, 32'h22222222);
        send(1, 1'b0, 32'h33333333);
        send(1, 1'b0, 32'h44444444);
        reset_pulse();

        // Basic launch, then key reuse with IN_VALID held through HOLD
        w = K1;
        for (int i = 0; i < 4; i++) begin
            send(1, 1'b1, w[127:96]);
            w = w << 32;
        end
        w = T1;
        for (int i = 0; i < 4; i++) begin
            send(1, 1'b0, w[127:96]);
            w = w << 32;
        end
        chk1("t2_no_early_blk", blk[1], 1'b0);
        chk1("t2_launch_busy", busy[1], 1'b1);
        iv[1] = 1'b1; isel[1] = 1'b0; idata[1] = 32'hb34d56f7;
        @(negedge clk);
        chk1("t2_blk", blk[1], 1'b1);
        chk("t2_key", akey[1], K1);
        chk("t2_plain", ptxt[1], T1);
        w = T2;
        for (int i = 0; i < 4; i++) begin
            send(1, 1'b0, w[127:96]);
            w = w << 32;
        end
        wait_idle(1);
        chk("t4_plain", ptxt[1], T2);
        chk("t4_key_reused", akey[1], K1);

        // No key reuse: text alone must not launch; extra text is stalled
        for (int i = 0; i < 4; i++) send(0, 1'b1, $urandom);
        for (int i = 0; i < 4; i++) send(0, 1'b0, $urandom);
        wait_idle(0);
        for (int i = 0; i < 4; i++) send(0, 1'b0, $urandom);
        repeat (10) @(negedge clk);
        chk1("t4_noreuse_keyloaded", kl[0], 1'b0);
        chk1("t4_noreuse_idle", busy[0], 1'b0);
        iv[0] = 1'b1; isel[0] = 1'b0; idata[0] = 32'hdeadbeef;
        cnt = 0;
        repeat (4) begin
            #1;
            if (ir[0]) cnt++;
            @(negedge clk);
        end
        iv[0] = 1'b0;
        chki("t5_text_stalled", cnt, 0);
        for (int i = 0; i < 4; i++) send(0, 1'b1, $urandom);
        wait_idle(0);

        // Reset during HOLD, then reload
        for (int i = 0; i < 4; i++) send(1, 1'b0, $urandom);
        repeat (3) @(negedge clk);
        chk1("t6_in_hold", busy[1], 1'b1);
        reset_pulse();
        for (int i = 0; i < 4; i++) send(1, 1'b0, $urandom);
        repeat (15) @(negedge clk);
        chk1("t6_no_launch_without_key", kl[1], 1'b0);
        for (int i = 0; i < 4; i++) send(1, 1'b1, $urandom);
        wait_idle(1);

        // Randomized traffic on both instances
        for (int d = 0; d < 2; d++) begin
            repeat (40) begin
                sel = 1'($urandom_range(0, 1));
                if (m_tf[d] && !sel) sel = 1'b1;
                send(d, sel, $urandom);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
            wait_idle(d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end
endmodule
